// File: rtl/serial_subtractor_v.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow flop.
// Computes diff = a - b (mod 2^WIDTH) LSB first, one bit per clock. The final
// borrow (bout) is 1 exactly when a < b. Uses a start/ready/done handshake.
module serial_subtractor_v #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic bit_a, bit_b, bit_d, bit_bn, last;

  // Full-subtractor cell on the current LSBs and the stored borrow
  assign bit_a  = areg_q[0];
  assign bit_b  = breg_q[0];
  assign bit_d  = bit_a ^ bit_b ^ borrow_q;
  assign bit_bn = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
  assign last   = (cnt_q == CntW'(WIDTH - 1));

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    areg_d   = areg_q;
    breg_d   = breg_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          areg_d   = a;
          breg_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        areg_d   = areg_q >> 1;
        breg_d   = breg_q >> 1;
        res_d    = {bit_d, res_q[WIDTH-1:1]};
        borrow_d = bit_bn;
        cnt_d    = last ? '0 : cnt_q + CntW'(1);
        if (last) begin
          // Publish the completed result so it is valid alongside done in FIN
          diff_d  = {bit_d, res_q[WIDTH-1:1]};
          bout_d  = bit_bn;
          state_d = StFin;
        end
      end
      StFin: begin
        if (start) begin
          areg_d   = a;
          breg_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered images of the next state
    ready_d = (state_d != StShift);
    busy_d  = (state_d == StShift);
    done_d  = (state_d == StFin);
  end

  // State, datapath and output registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      areg_q   <= '0;
      breg_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      areg_q   <= areg_d;
      breg_q   <= breg_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor_v.sv
// Directed and short random checks of serial_subtractor_v with WIDTH=8.
module tb_serial_subtractor_v;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor_v #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done with a bound; returns cycles waited and busy cycles seen
  task automatic wait_done(output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    while (!done && cyc < 30) begin
      if (busy) nbusy++;
      tick();
      cyc++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Full operation: pulse start for one cycle, wait for done, check result
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input string tag);
    int cyc, nbusy;
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, nbusy);
    check({tag, "_lat"}, cyc, 8);
    check({tag, "_busy"}, nbusy, 8);
    check({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_diff_hold"}, {24'd0, diff}, {24'd0, ed});
  endtask

  initial begin
    int cyc, nbusy, extra;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #22;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_op(8'd200, 8'd55, 8'd145, 1'b0, "op200_55");
    do_op(8'd5, 8'd9, 8'd252, 1'b1, "op5_9");
    do_op(8'd0, 8'd255, 8'd1, 1'b1, "op0_255");
    do_op(8'd77, 8'd77, 8'd0, 1'b0, "op77_77");

    // start pulsed mid-operation must be ignored
    a = 8'd200; b = 8'd55; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("ign_ready", {31'd0, ready}, 32'd0);
    a = 8'd1; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, nbusy);
    check("ign_lat", cyc, 5);
    check("ign_diff", {24'd0, diff}, 32'd145);
    tick();
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) extra++;
      tick();
    end
    check("ign_no_extra_done", extra, 0);

    // Back-to-back: start held on the FIN cycle
    a = 8'd200; b = 8'd55; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, nbusy);
    check("b2b_first_diff", {24'd0, diff}, 32'd145);
    check("b2b_fin_ready", {31'd0, ready}, 32'd1);
    a = 8'd10; b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_no_idle", {31'd0, busy}, 32'd1);
    wait_done(cyc, nbusy);
    check("b2b_gap", cyc + 1, 9);
    check("b2b_diff", {24'd0, diff}, 32'd7);
    check("b2b_bout", {31'd0, bout}, 32'd0);
    tick();

    // Reset during the 4th SHIFT cycle
    a = 8'd200; b = 8'd55; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_diff", {24'd0, diff}, 32'd0);
    check("mid_rst_bout", {31'd0, bout}, 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    do_op(8'd3, 8'd4, 8'd255, 1'b1, "post_rst");

    // Random operands against the arithmetic reference
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, ra - rb, (ra < rb), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
